// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and trap sequencer.
package csr_pkg;

    // Implemented machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    // Synchronous exception codes delivered by decode_control
    localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

    // Platform interrupt line k reports mcause code IRQ_CODE_BASE + k
    localparam logic [4:0] IRQ_CODE_BASE = 5'd16;

    // mstatus field positions
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        TRAP_RD = 2'd2,
        RET     = 2'd3
    } trap_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder for the platform interrupt lines.
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic         any,
    output logic [3:0]   idx
);

    // Scan from the top so the lowest set index is the last one kept
    always_comb begin
        any = 1'b0;
        idx = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = req[i] ? 4'(i) : idx;
            any = any | req[i];
        end
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file plus trap/MRET sequencer driving the fetch redirect.
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               csr_op_valid,
    input  logic [2:0]         csr_func3,
    input  logic [11:0]        csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    input  logic               mret_valid,
    input  logic               exc_valid,
    input  logic [3:0]         exc_cause,
    input  logic [XLEN-1:0]    instr_pc,
    input  logic               pipe_ready,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic               trap_req,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc
);

    // Only the platform-interrupt enable bits of mie are writable
    localparam logic [XLEN-1:0] MIE_MASK = ((32'h1 << NUM_IRQ) - 32'h1) << 16;

    trap_state_t      state_q, state_d;
    logic             mstatus_mie_q, mstatus_mie_d;
    logic             mstatus_mpie_q, mstatus_mpie_d;
    logic [XLEN-1:0]  mie_q, mie_d;
    logic [NUM_IRQ-1:0] mip_q, mip_d;
    logic [XLEN-1:0]  mtvec_q, mtvec_d;
    logic [XLEN-1:0]  mscratch_q, mscratch_d;
    logic [XLEN-1:0]  mepc_q, mepc_d;
    logic [XLEN-1:0]  mcause_q, mcause_d;
    logic             trap_req_q, trap_req_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;

    logic [XLEN-1:0]    rdata_s;
    logic [XLEN-1:0]    wr_val_s;
    logic               csr_wr_en_s;
    logic [NUM_IRQ-1:0] pend_s;
    logic               pend_any_s;
    logic [3:0]         pend_idx_s;
    logic               irq_take_s;
    logic [XLEN-1:0]    mtvec_base_s;

    // Mode 01 is the only mode kept, and only when vectoring is allowed
    function automatic logic [XLEN-1:0] legal_mtvec(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        if (VECTORED_EN && (v[1:0] == 2'b01)) begin
            r = v;
        end else begin
            r = {v[XLEN-1:2], 2'b00};
        end
        return r;
    endfunction

    assign pend_s = mip_q & mie_q[16 +: NUM_IRQ];

    irq_prio_enc #(.N(NUM_IRQ)) u_irq_prio_enc (
        .req (pend_s),
        .any (pend_any_s),
        .idx (pend_idx_s)
    );

    assign irq_take_s   = pend_any_s & mstatus_mie_q & pipe_ready;
    assign csr_wr_en_s  = csr_op_valid && (csr_func3 != 3'b000) && (csr_func3[1:0] != 2'b00);
    assign mtvec_base_s = {mtvec_q[XLEN-1:2], 2'b00};

    // Combinational CSR read port; unimplemented addresses read zero
    always_comb begin
        rdata_s = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                rdata_s[12:11]            = 2'b11;
                rdata_s[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
                rdata_s[MSTATUS_MIE_BIT]  = mstatus_mie_q;
            end
            CSR_MIE:      rdata_s = mie_q;
            CSR_MTVEC:    rdata_s = mtvec_q;
            CSR_MSCRATCH: rdata_s = mscratch_q;
            CSR_MEPC:     rdata_s = mepc_q;
            CSR_MCAUSE:   rdata_s = mcause_q;
            CSR_MIP:      rdata_s[16 +: NUM_IRQ] = mip_q;
            default:      rdata_s = '0;
        endcase
    end

    assign csr_rdata = rdata_s;

    // New CSR value for write/set/clear against the old contents
    always_comb begin
        wr_val_s = rdata_s;
        case (csr_func3[1:0])
            2'b01:   wr_val_s = csr_wdata;
            2'b10:   wr_val_s = rdata_s | csr_wdata;
            2'b11:   wr_val_s = rdata_s & ~csr_wdata;
            default: wr_val_s = rdata_s;
        endcase
    end

    // Event arbitration, CSR updates and next-state/output computation
    always_comb begin
        state_d          = state_q;
        mstatus_mie_d    = mstatus_mie_q;
        mstatus_mpie_d   = mstatus_mpie_q;
        mie_d            = mie_q;
        mip_d            = irq_i;
        mtvec_d          = mtvec_q;
        mscratch_d       = mscratch_q;
        mepc_d           = mepc_q;
        mcause_d         = mcause_q;
        trap_req_d       = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
        case (state_q)
            IDLE: begin
                if (exc_valid || irq_take_s) begin
                    mepc_d         = instr_pc & ~32'h0000_0003;
                    mstatus_mpie_d = mstatus_mie_q;
                    mstatus_mie_d  = 1'b0;
                    trap_req_d     = 1'b1;
                    state_d        = FLUSH;
                    if (exc_valid) begin
                        mcause_d = {1'b0, 27'd0, exc_cause};
                    end else begin
                        mcause_d = {1'b1, 26'd0, IRQ_CODE_BASE + {1'b0, pend_idx_s}};
                    end
                end else if (mret_valid) begin
                    mstatus_mie_d    = mstatus_mpie_q;
                    mstatus_mpie_d   = 1'b1;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = mepc_q;
                    state_d          = RET;
                end else if (csr_wr_en_s) begin
                    case (csr_addr)
                        CSR_MSTATUS: begin
                            mstatus_mie_d  = wr_val_s[MSTATUS_MIE_BIT];
                            mstatus_mpie_d = wr_val_s[MSTATUS_MPIE_BIT];
                        end
                        CSR_MIE:      mie_d      = wr_val_s & MIE_MASK;
                        CSR_MTVEC:    mtvec_d    = legal_mtvec(wr_val_s);
                        CSR_MSCRATCH: mscratch_d = wr_val_s;
                        CSR_MEPC:     mepc_d     = wr_val_s & ~32'h0000_0003;
                        CSR_MCAUSE:   mcause_d   = wr_val_s;
                        default:      mscratch_d = mscratch_q;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                redirect_valid_d = 1'b1;
                state_d          = TRAP_RD;
                if (mtvec_q[0] && mcause_q[31]) begin
                    redirect_pc_d = mtvec_base_s + {25'd0, mcause_q[4:0], 2'b00};
                end else begin
                    redirect_pc_d = mtvec_base_s;
                end
            end
            TRAP_RD: state_d = IDLE;
            RET:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, CSR and registered-output flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            mstatus_mie_q    <= 1'b0;
            mstatus_mpie_q   <= 1'b0;
            mie_q            <= '0;
            mip_q            <= '0;
            mtvec_q          <= MTVEC_RESET;
            mscratch_q       <= '0;
            mepc_q           <= '0;
            mcause_q         <= '0;
            trap_req_q       <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            mstatus_mie_q    <= mstatus_mie_d;
            mstatus_mpie_q   <= mstatus_mpie_d;
            mie_q            <= mie_d;
            mip_q            <= mip_d;
            mtvec_q          <= mtvec_d;
            mscratch_q       <= mscratch_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            trap_req_q       <= trap_req_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign trap_req       = trap_req_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Machine-mode CSR file and trap sequencer for the RV32 core. It consumes the CSR/MRET/exception qualifiers produced by decode_control at the commit stage. It holds the M-mode CSRs, arbitrates exceptions, `NUM_IRQ` prioritised interrupt lines and MRET, and drives a flush/redirect handshake to the fetch stage. It supports direct and vectored `mtvec`.

## Interface
- `XLEN`, 32: data width; only 32 is supported.
- `NUM_IRQ`, 4: platform interrupt lines, 1..16. Line k maps to mcause code 16+k and to enable bit mie[16+k].
- `MTVEC_RESET`, 32'h0000_0000: reset value of mtvec.
- `VECTORED_EN`, 1: 1 allows mtvec mode 01. At 0, any written mode field is forced to 00.
- `clk`  in  1  core clock
- `reset_n`  in  1  asynchronous active-low reset; the only reset.
- `csr_op_valid`  in  1  CSR instruction at commit (is_csr_instr & stage valid)
- `csr_func3`  in  3  func3 of the CSR instruction
- `csr_addr`  in  12  CSR address
- `csr_wdata`  in  XLEN  rs1 value or zero-extended zimm, selected upstream by csr_data_sel
- `csr_rdata`  out  XLEN  old CSR value, combinational; 0 for unimplemented addresses
- `mret_valid`  in  1  MRET at commit
- `exc_valid`  in  1  synchronous exception at commit
- `exc_cause`  in  4  exception code (2 illegal, 3 ebreak, 11 ecall)
- `instr_pc`  in  XLEN  PC of the commit-stage instruction
- `pipe_ready`  in  1  commit stage holds a valid, interruptible instruction
- `irq_i`  in  NUM_IRQ  level-sensitive interrupt requests, synchronous to clk
- `trap_req`  out  1  flush request; squashes the commit instruction and everything younger
- `redirect_valid`  out  1  one-cycle fetch redirect strobe
- `redirect_pc`  out  XLEN  redirect target; valid only while redirect_valid is high

## Operation
- **Implemented CSRs:**
  - mstatus 0x300: MIE bit 3, MPIE bit 7, MPP[12:11] reads 11; all other bits read 0.
  - mie 0x304
  - mtvec 0x305
  - mscratch 0x340
  - mepc 0x341: bits [1:0] forced to 0.
  - mcause 0x342: bit 31 is the interrupt flag.
  - mip 0x344: read-only; a write is ignored.
- **CSR ops:** func3[1:0] selects the operation: 01 writes, 10 sets (old | wdata), 11 clears (old & ~wdata). func3 == 000 is not a CSR op.
  - A write to an unimplemented address is dropped.
- **Interrupt pending:** irq_i is registered once into mip. An interrupt is taken when `pend = mip & mie[16+:NUM_IRQ]` is nonzero, mstatus.MIE = 1 and pipe_ready = 1. The lowest index wins.
- **Event priority in IDLE:** exc_valid > interrupt > mret_valid > csr_op_valid. The winning event suppresses every lower one, including its CSR write.
- **FSM states:**
  - IDLE
    - On exception or interrupt at the clock edge: mepc <= instr_pc; mcause <= {irq, 27'b0, code}; MPIE <= MIE; MIE <= 0. Go to FLUSH.
    - On MRET: MIE <= MPIE; MPIE <= 1. Go to RET.
    - On a CSR op: apply the write. Stay in IDLE.
  - FLUSH: trap_req = 1. Go to TRAP_RD.
  - TRAP_RD: redirect_valid = 1. redirect_pc = mtvec base, or base + 4·code for a vectored interrupt. Exceptions always go to the base. Go to IDLE.
  - RET: redirect_valid = 1; redirect_pc = mepc. Go to IDLE.
- All inputs are ignored outside IDLE.

## Timing
- **Reset values:**
  - Outputs: trap_req = 0, redirect_valid = 0, redirect_pc = 0. csr_rdata follows the reset CSR contents.
  - State: FSM IDLE; mstatus.MIE = 0, MPIE = 0.
  - CSRs: mie, mip, mepc, mcause and mscratch = 0; mtvec = MTVEC_RESET.
- CSR write is visible on csr_rdata the cycle after the op.
- **Trap latency:** event at edge N; trap_req high in cycle N+1; redirect_valid high in cycle N+2; IDLE again in cycle N+3.
- **MRET latency:** redirect_valid high in cycle N+1.
- **IRQ latency:** an irq_i rise is seen in mip one cycle later; the trap is taken on the following eligible edge.
- **MRET with a pending, now-enabled interrupt:** MRET completes first. The interrupt is taken on the first eligible IDLE cycle after RET, with mepc = instr_pc of that cycle.
- **Reset mid-sequence:** reset in FLUSH, TRAP_RD or RET aborts the sequence. State returns to IDLE and all outputs drop in the same cycle.

## Structure
- Shared package `csr_pkg` holds:
  - CSR address localparams
  - mcause code constants
  - bit positions for mstatus MIE/MPIE
  - the `trap_state_t` enum {IDLE, FLUSH, TRAP_RD, RET}
- One sub-module, `irq_prio_enc`: parametrised NUM_IRQ-bit lowest-index priority encoder with outputs any and idx.

## Test plan
- **CSR write/set/clear:** CSRRW 0x340 ← 0xA5A5_0000, then CSRRS ← 0x0F, then CSRRC ← 0xA500_0000. csr_rdata reads 0x0000_0000, 0xA5A5_0000, 0xA5A5_000F; final value 0x00A5_000F.
- **Ecall:** exc_valid with cause 11 at instr_pc 0x100, mtvec 0x200. trap_req in cycle +1; redirect_pc 0x200 in cycle +2; mepc 0x100; mcause 0x0000_000B; MIE 1→0; MPIE = 1.
- **Vectored interrupt:** mtvec 0x401, mie bits 17 and 18 set, MIE = 1, irq_i = 4'b0110. Line 1 wins; mcause 0x8000_0011; redirect_pc 0x444.
- **MRET:** mepc 0x104, MPIE = 1. mret_valid gives redirect_pc 0x104 one cycle later, MIE = 1, MPIE = 1.
- **Priority:** exc_valid, a pending interrupt and csr_op_valid (write mscratch 0x1) in the same cycle. The exception trap is taken; mscratch stays unchanged.
- **Reset mid-trap:** reset_n asserted in FLUSH. Outputs 0 immediately, state IDLE, mtvec = MTVEC_RESET.
